stress_trend: RTL and testbench

- Parametrised successor to the two-channel cry/heart-rate delta detector in the controller.
- Tracks N input channels, each a sampled sensor value such as cry volume or heart rate, and compares the top SLICE_W bits of each new sample with the previous sample.
- Declares a falling trend (stress_laag) or rising trend (stress_hoog) only after HOLD consecutive moves in the same direction.
- Outputs feed the rocking-mode state machine.

---
 rtl/stress_trend_if.sv | 24 ++
 rtl/stress_trend.sv | 94 +++++++++
 tb/tb_stress_trend.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stress_trend_if.sv
// Sample/decision bundle between the sensor front end and stress_trend.
// master drives samples and mask; slave returns trends and decisions.
interface stress_trend_if #(
  parameter int N_CH = 2,
  parameter int IN_W = 8
);
  logic                   sample_en;
  logic [N_CH*IN_W-1:0]   ch_data;
  logic [N_CH-1:0]        ch_mask;
  logic [2*N_CH-1:0]      trend;
  logic                   valid;
  logic                   stress_laag;
  logic                   stress_hoog;

  modport master (
    output sample_en, ch_data, ch_mask,
    input  trend, valid, stress_laag, stress_hoog
  );

  modport slave (
    input  sample_en, ch_data, ch_mask,
    output trend, valid, stress_laag, stress_hoog
  );
endinterface

// File: rtl/stress_trend.sv
// Per-channel rising/falling trend detector on sample MSB slices.
// Build with STRESS_ALL_EN to require all masked channels to agree.
module stress_trend #(
  parameter int N_CH    = 2,
  parameter int IN_W    = 8,
  parameter int SLICE_W = 3,
  parameter int HOLD    = 2
) (
  input  logic           clk,
  input  logic           r,
  stress_trend_if.slave  bus
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  logic [SLICE_W-1:0] prev    [N_CH];
  logic [SLICE_W-1:0] cur     [N_CH];
  logic [CW-1:0]      downCnt [N_CH];
  logic [CW-1:0]      upCnt   [N_CH];
  logic               primed;

  logic [N_CH-1:0]    rising;
  logic [N_CH-1:0]    falling;
  logic [2*N_CH-1:0]  trendNext;
  logic               hoogRaw;
  logic               laagRaw;

  always_comb begin
    trendNext = '0;
    rising    = '0;
    falling   = '0;
    for (int c = 0; c < N_CH; c++) begin
      cur[c]     = bus.ch_data[c*IN_W+IN_W-1 -: SLICE_W];
      rising[c]  = (upCnt[c] == HOLD_C);
      falling[c] = (downCnt[c] == HOLD_C);
      trendNext[2*c]   = falling[c];
      trendNext[2*c+1] = rising[c];
    end
  end

  // Unmasked channels count as satisfied in the all-channels variant.
  always_comb begin
`ifdef STRESS_ALL_EN
    hoogRaw = (|bus.ch_mask) & (&(rising  | ~bus.ch_mask));
    laagRaw = (|bus.ch_mask) & (&(falling | ~bus.ch_mask));
`else
    hoogRaw = |(rising  & bus.ch_mask);
    laagRaw = |(falling & bus.ch_mask);
`endif
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      primed <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        prev[c]    <= '0;
        downCnt[c] <= '0;
        upCnt[c]   <= '0;
      end
    end else if (bus.sample_en) begin
      primed <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        prev[c] <= cur[c];
        if (primed) begin
          if (cur[c] < prev[c]) begin
            upCnt[c] <= '0;
            if (downCnt[c] != HOLD_C)
              downCnt[c] <= downCnt[c] + 1'b1;
          end else if (cur[c] > prev[c]) begin
            downCnt[c] <= '0;
            if (upCnt[c] != HOLD_C)
              upCnt[c] <= upCnt[c] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      bus.trend       <= '0;
      bus.valid       <= 1'b0;
      bus.stress_laag <= 1'b0;
      bus.stress_hoog <= 1'b0;
    end else begin
      bus.trend       <= trendNext;
      bus.valid       <= primed;
      bus.stress_hoog <= hoogRaw;
      bus.stress_laag <= laagRaw & ~hoogRaw;
    end
  end

endmodule

// File: tb/tb_stress_trend.sv
// Randomized and directed bench for stress_trend against a streak model.
// Honors STRESS_ALL_EN in the reference decision.
module tb_stress_trend;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic r   = 1'b0;

  stress_trend_if #(.N_CH(2), .IN_W(8)) bus ();

  stress_trend #(
    .N_CH(2), .IN_W(8), .SLICE_W(3), .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .r(r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: direction of the current run of strict moves and its length.
  int  mDir    [2] = '{0, 0};
  int  mStreak [2] = '{0, 0};
  int  mLast   [2] = '{0, 0};
  bit  mPrimed = 1'b0;
  logic [6:0] expVec;

  function automatic logic [6:0] got();
    return {bus.trend, bus.valid, bus.stress_laag, bus.stress_hoog};
  endfunction

  function automatic logic [6:0] modelOut(input logic [1:0] m);
    logic [1:0] ri, fa;
    logic h, l;
    for (int c = 0; c < 2; c++) begin
      ri[c] = (mDir[c] == 1)  && (mStreak[c] >= HOLD);
      fa[c] = (mDir[c] == -1) && (mStreak[c] >= HOLD);
    end
`ifdef STRESS_ALL_EN
    h = (m != 2'b00) && ((ri | ~m) == 2'b11);
    l = (m != 2'b00) && ((fa | ~m) == 2'b11);
`else
    h = |(ri & m);
    l = |(fa & m);
`endif
    l = l & ~h;
    return {ri[1], fa[1], ri[0], fa[0], mPrimed, l, h};
  endfunction

  task automatic modelSample(input logic [7:0] d0, input logic [7:0] d1);
    int s [2];
    s[0] = int'(d0[7:5]);
    s[1] = int'(d1[7:5]);
    for (int c = 0; c < 2; c++) begin
      if (mPrimed && s[c] < mLast[c]) begin
        if (mDir[c] == -1) mStreak[c]++;
        else begin mDir[c] = -1; mStreak[c] = 1; end
      end else if (mPrimed && s[c] > mLast[c]) begin
        if (mDir[c] == 1) mStreak[c]++;
        else begin mDir[c] = 1; mStreak[c] = 1; end
      end
      mLast[c] = s[c];
    end
    mPrimed = 1'b1;
  endtask

  task automatic step(input bit rst, input bit en,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] m);
    r = ~rst;
    bus.sample_en = en;
    bus.ch_data = {d1, d0};
    bus.ch_mask = m;
    @(posedge clk);
    expVec = rst ? 7'd0 : modelOut(m);
    if (rst) begin
      mPrimed = 1'b0;
      for (int c = 0; c < 2; c++) begin
        mDir[c] = 0; mStreak[c] = 0; mLast[c] = 0;
      end
    end else if (en) begin
      modelSample(d0, d1);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'($urandom), 8'($urandom), 2'b11);
      total++;
      if (got() !== 7'd0) begin
        bad++;
        $display("FAIL reset_hold got=%b want=%b", got(), 7'd0);
      end
    end
    step(0, 1, 8'h80, 8'h80, 2'b11);
    step(0, 0, 8'h80, 8'h80, 2'b11);
    total++;
    if (got() !== 7'b0000_100) begin
      bad++;
      $display("FAIL reset_prime got=%b want=%b", got(), 7'b0000100);
    end
  endtask

  task automatic test_falling();
    logic [7:0] seq [3] = '{8'hE0, 8'hC0, 8'hA0};
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, seq[i], 8'h40, 2'b11);
      total++;
      if (got() !== expVec) begin
        bad++;
        $display("FAIL falling_seq got=%b want=%b", got(), expVec);
      end
    end
    step(0, 0, 8'hA0, 8'h40, 2'b11);
    total++;
    if ({bus.trend[1:0], bus.stress_laag, bus.stress_hoog} !== 4'b0110) begin
      bad++;
      $display("FAIL falling_det got=%b want=%b",
               {bus.trend[1:0], bus.stress_laag, bus.stress_hoog}, 4'b0110);
    end
  endtask

  task automatic test_rising();
    logic [7:0] seq [4] = '{8'h20, 8'h60, 8'hA0, 8'hA0};
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h80, seq[i], 2'b11);
      total++;
      if (got() !== expVec) begin
        bad++;
        $display("FAIL rising_seq got=%b want=%b", got(), expVec);
      end
    end
    step(0, 0, 8'h80, 8'hA0, 2'b11);
    total++;
    if ({bus.trend[3:2], bus.stress_hoog} !== 3'b101) begin
      bad++;
      $display("FAIL rising_hold got=%b want=%b",
               {bus.trend[3:2], bus.stress_hoog}, 3'b101);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] a [3] = '{8'hE0, 8'hC0, 8'hA0};
    logic [7:0] b [3] = '{8'h20, 8'h60, 8'hA0};
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 3; i++) step(0, 1, a[i], b[i], 2'b11);
    step(0, 0, 8'hA0, 8'hA0, 2'b11);
    total++;
    if (got() !== 7'b1001_101) begin
      bad++;
      $display("FAIL conflict got=%b want=%b", got(), 7'b1001101);
    end
  endtask

  task automatic test_subslice();
    logic [7:0] seq [6] = '{8'hE0, 8'hFF, 8'hE0, 8'hC0, 8'hE0, 8'hC0};
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, seq[i], 8'h40, 2'b11);
      total++;
      if (bus.stress_laag !== 1'b0 || got() !== expVec) begin
        bad++;
        $display("FAIL subslice got=%b want=%b", got(), expVec);
      end
    end
    step(0, 0, 8'hC0, 8'h40, 2'b11);
    total++;
    if (bus.stress_laag !== 1'b0) begin
      bad++;
      $display("FAIL subslice_end got=%b want=0", bus.stress_laag);
    end
  endtask

  task automatic test_mask_reset();
    logic [7:0] seq [3] = '{8'hE0, 8'hC0, 8'hA0};
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 3; i++) step(0, 1, seq[i], 8'h40, 2'b11);
    step(0, 0, 8'hA0, 8'h40, 2'b11);
    step(0, 0, 8'hA0, 8'h40, 2'b10);
    total++;
    if ({bus.trend[0], bus.stress_laag} !== 2'b10) begin
      bad++;
      $display("FAIL mask_clear got=%b want=%b",
               {bus.trend[0], bus.stress_laag}, 2'b10);
    end
    step(1, 0, 8'hA0, 8'h40, 2'b11);
    total++;
    if ({bus.trend, bus.valid} !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=%b", {bus.trend, bus.valid}, 5'd0);
    end
    step(0, 1, 8'hC0, 8'h40, 2'b11);
    step(0, 1, 8'hA0, 8'h40, 2'b11);
    step(0, 0, 8'hA0, 8'h40, 2'b11);
    total++;
    if (bus.stress_laag !== 1'b0) begin
      bad++;
      $display("FAIL reprime_early got=%b want=0", bus.stress_laag);
    end
    step(0, 1, 8'h80, 8'h40, 2'b11);
    step(0, 0, 8'h80, 8'h40, 2'b11);
    total++;
    if (bus.stress_laag !== 1'b1) begin
      bad++;
      $display("FAIL reprime_late got=%b want=1", bus.stress_laag);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 2'b11);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7,
           8'($urandom), 8'($urandom),
           2'($urandom));
      total++;
      if (got() !== expVec) begin
        bad++;
        $display("FAIL random[%0d] got=%b want=%b", i, got(), expVec);
      end
    end
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.ch_data   = '0;
    bus.ch_mask   = 2'b11;
    test_reset();
    test_falling();
    test_rising();
    test_conflict();
    test_subslice();
    test_mask_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
